// File: rtl/tag_store_responder.sv
// Direct-mapped DRAM-cache tag array with an in-order lookup response FIFO.
// Lookups read the array combinationally, with bypass from a same-cycle update.
module tag_store_responder #(
   parameter int TAG_BIT_SIZE = 8,
   parameter int INDEX_BITS   = 6,
   parameter int OUT_DEPTH    = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   input  logic [63:0]             req_addr_i,
   input  logic                    upd_valid_i,
   input  logic [INDEX_BITS-1:0]   upd_index_i,
   input  logic [TAG_BIT_SIZE-1:0] upd_tag_i,
   input  logic                    upd_dirty_i,
   input  logic                    upd_inval_i,
   output logic [TAG_BIT_SIZE-1:0] rtag_o,
   output logic [63:0]             rdata_o,
   output logic                    rvalid_o,
   input  logic                    rready_i
);

   localparam int SETS  = 2**INDEX_BITS;
   localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
   localparam int CNT_W = $clog2(OUT_DEPTH) + 1;

   logic [TAG_BIT_SIZE-1:0] tag_q [SETS];
   logic [SETS-1:0]         valid_q;
   logic [SETS-1:0]         dirty_q;

   logic [TAG_BIT_SIZE-1:0] fifo_tag_q  [OUT_DEPTH];
   logic [63:0]             fifo_data_q [OUT_DEPTH];
   logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]        count_q, count_d;
   logic                    rdy_en_q;

   logic [INDEX_BITS-1:0]   lk_idx;
   logic                    lk_bypass;
   logic [TAG_BIT_SIZE-1:0] lk_tag;
   logic                    lk_valid;
   logic                    lk_dirty;
   logic                    push;
   logic                    pop;
   logic                    unused_addr;

   assign unused_addr = ^req_addr_i[1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SETS; i++) begin
            tag_q[i] <= '0;
         end
         valid_q <= '0;
         dirty_q <= '0;
      end else if (upd_valid_i) begin
         if (upd_inval_i) begin
            valid_q[upd_index_i] <= 1'b0;
            dirty_q[upd_index_i] <= 1'b0;
         end else begin
            valid_q[upd_index_i] <= 1'b1;
            dirty_q[upd_index_i] <= upd_dirty_i;
            tag_q[upd_index_i]   <= upd_tag_i;
         end
      end
   end

   // A same-cycle update to the looked-up set wins; invalidate keeps the old tag.
   always_comb begin
      lk_idx    = req_addr_i[INDEX_BITS+5:6];
      lk_bypass = upd_valid_i && (upd_index_i == lk_idx);
      lk_tag    = tag_q[lk_idx];
      lk_valid  = valid_q[lk_idx];
      lk_dirty  = dirty_q[lk_idx];
      if (lk_bypass) begin
         if (upd_inval_i) begin
            lk_valid = 1'b0;
            lk_dirty = 1'b0;
         end else begin
            lk_tag   = upd_tag_i;
            lk_valid = 1'b1;
            lk_dirty = upd_dirty_i;
         end
      end
   end

   // Ready depends only on registered state, never on rready_i.
   assign req_ready_o = rdy_en_q && (count_q < CNT_W'(OUT_DEPTH));
   assign rvalid_o    = (count_q != '0);
   assign rtag_o      = fifo_tag_q[rd_ptr_q];
   assign rdata_o     = fifo_data_q[rd_ptr_q];
   assign push        = req_valid_i && req_ready_o;
   assign pop         = rvalid_o && rready_i;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < OUT_DEPTH; i++) begin
            fifo_tag_q[i]  <= '0;
            fifo_data_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         rdy_en_q <= 1'b0;
      end else begin
         if (push) begin
            fifo_tag_q[wr_ptr_q]  <= lk_tag;
            fifo_data_q[wr_ptr_q] <= {req_addr_i[63:2], lk_dirty, lk_valid};
         end
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         rdy_en_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_tag_store_responder.sv
// Directed bench for tag_store_responder: a reference tag array predicts each
// response when its request is accepted; a monitor pops and compares on handshake.
module tb_tag_store_responder;

   typedef struct packed {
      logic [7:0]  tag;
      logic [63:0] data;
   } resp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [63:0] req_addr_i;
   logic        upd_valid_i;
   logic [5:0]  upd_index_i;
   logic [7:0]  upd_tag_i;
   logic        upd_dirty_i;
   logic        upd_inval_i;
   logic [7:0]  rtag_o;
   logic [63:0] rdata_o;
   logic        rvalid_o;
   logic        rready_i;

   int    n_assert = 0;
   int    n_fail   = 0;
   int    n_pops   = 0;
   resp_t sb[$];

   logic [7:0] m_tag   [64];
   logic       m_valid [64];
   logic       m_dirty [64];

   tag_store_responder #(.TAG_BIT_SIZE(8), .INDEX_BITS(6), .OUT_DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
      .upd_valid_i(upd_valid_i), .upd_index_i(upd_index_i), .upd_tag_i(upd_tag_i),
      .upd_dirty_i(upd_dirty_i), .upd_inval_i(upd_inval_i),
      .rtag_o(rtag_o), .rdata_o(rdata_o), .rvalid_o(rvalid_o), .rready_i(rready_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", name, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 64; i++) begin
         m_tag[i]   = 8'h00;
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
      end
   endtask

   // Update the model first: a same-cycle lookup must see the written values.
   task automatic step(output bit acc);
      resp_t r;
      int    idx;
      acc = rst_n && req_valid_i && req_ready_o;
      if (rst_n && upd_valid_i) begin
         if (upd_inval_i) begin
            m_valid[upd_index_i] = 1'b0;
            m_dirty[upd_index_i] = 1'b0;
         end else begin
            m_valid[upd_index_i] = 1'b1;
            m_dirty[upd_index_i] = upd_dirty_i;
            m_tag[upd_index_i]   = upd_tag_i;
         end
      end
      if (acc) begin
         idx    = int'(req_addr_i[11:6]);
         r.tag  = m_tag[idx];
         r.data = {req_addr_i[63:2], m_dirty[idx], m_valid[idx]};
         sb.push_back(r);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic lookup(input logic [63:0] addr);
      bit acc = 1'b0;
      req_valid_i = 1'b1;
      req_addr_i  = addr;
      for (int k = 0; k < 20 && !acc; k++) begin
         step(acc);
      end
      req_valid_i = 1'b0;
      chk("lookup_accepted", 64'(acc), 64'd1);
   endtask

   task automatic drain();
      bit dummy;
      for (int k = 0; k < 20 && sb.size() != 0; k++) begin
         step(dummy);
      end
      chk("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   always @(negedge clk) begin
      resp_t r;
      if (rst_n && rvalid_o && rready_i) begin
         n_pops++;
         n_assert++;
         assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL unexpected_resp: observed tag %h data %h expected none", rtag_o, rdata_o);
         end
         if (sb.size() != 0) begin
            r = sb.pop_front();
            chk("resp_tag", 64'(rtag_o), 64'(r.tag));
            chk("resp_data", rdata_o, r.data);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit          acc;
      int          n_acc;
      int          p0;
      logic [7:0]  hold_tag;
      logic [63:0] hold_data;

      rst_n = 1'b0; req_valid_i = 1'b0; req_addr_i = '0;
      upd_valid_i = 1'b0; upd_index_i = '0; upd_tag_i = '0;
      upd_dirty_i = 1'b0; upd_inval_i = 1'b0; rready_i = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rvalid", 64'(rvalid_o), 64'd0);
      chk("rst_rtag", 64'(rtag_o), 64'd0);
      chk("rst_rdata", rdata_o, 64'd0);
      chk("rst_ready", 64'(req_ready_o), 64'd0);
      rst_n = 1'b1;
      step(acc);
      chk("ready_after_release", 64'(req_ready_o), 64'd1);

      // 1: lookup of a never-written set, latency 1
      req_valid_i = 1'b1;
      req_addr_i  = 64'h0000_0000_0000_0040;
      step(acc);
      req_valid_i = 1'b0;
      chk("t1_accepted", 64'(acc), 64'd1);
      chk("t1_latency_rvalid", 64'(rvalid_o), 64'd1);
      drain();

      // 2: fill then hit
      upd_valid_i = 1'b1; upd_index_i = 6'd1; upd_tag_i = 8'hA5; upd_dirty_i = 1'b1;
      step(acc);
      upd_valid_i = 1'b0;
      lookup(64'hA500_0000_0000_0040);
      drain();

      // 3: backpressure with a full FIFO
      rready_i = 1'b0;
      lookup(64'h1100_0000_0000_0080);
      lookup(64'h2200_0000_0000_00C4);
      req_valid_i = 1'b1;
      req_addr_i  = 64'h3300_0000_0000_0108;
      chk("t3_full_ready", 64'(req_ready_o), 64'd0);
      chk("t3_rvalid", 64'(rvalid_o), 64'd1);
      hold_tag  = rtag_o;
      hold_data = rdata_o;
      step(acc);
      chk("t3_third_blocked", 64'(acc), 64'd0);
      chk("t3_stable_tag", 64'(rtag_o), 64'(hold_tag));
      chk("t3_stable_data", rdata_o, hold_data);
      chk("t3_stable_rvalid", 64'(rvalid_o), 64'd1);
      rready_i = 1'b1;
      step(acc);
      chk("t3_full_pop_no_accept", 64'(acc), 64'd0);
      lookup(64'h3300_0000_0000_0108);
      drain();

      // 4: same-cycle update/lookup bypass, then invalidate
      upd_valid_i = 1'b1; upd_index_i = 6'd3; upd_tag_i = 8'h3C; upd_dirty_i = 1'b0;
      req_valid_i = 1'b1; req_addr_i = 64'h3C00_0000_0000_00C0;
      step(acc);
      upd_valid_i = 1'b0; req_valid_i = 1'b0;
      chk("t4_bypass_accepted", 64'(acc), 64'd1);
      drain();
      upd_valid_i = 1'b1; upd_index_i = 6'd3; upd_inval_i = 1'b1;
      upd_tag_i = 8'hFF; upd_dirty_i = 1'b1;
      step(acc);
      upd_valid_i = 1'b0; upd_inval_i = 1'b0;
      lookup(64'h3C00_0000_0000_00C0);
      drain();

      // 5: streaming, one response per cycle
      p0 = n_pops;
      n_acc = 0;
      req_valid_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         req_addr_i = {8'(i * 17), 50'd0, 6'(i), 6'd0};
         if (i == 4) begin
            upd_valid_i = 1'b1; upd_index_i = 6'd5; upd_tag_i = 8'h5A; upd_dirty_i = 1'b1;
         end else begin
            upd_valid_i = 1'b0;
         end
         step(acc);
         if (acc) n_acc++;
         if (i > 0) chk("t5_rvalid_each_cycle", 64'(rvalid_o), 64'd1);
      end
      req_valid_i = 1'b0; upd_valid_i = 1'b0;
      chk("t5_all_accepted", 64'(n_acc), 64'd10);
      step(acc);
      chk("t5_pop_count", 64'(n_pops - p0), 64'd10);
      drain();

      // 6: reset with responses queued
      rready_i = 1'b0;
      lookup(64'hA500_0000_0000_0040);
      lookup(64'h0000_0000_0000_0140);
      chk("t6_queued", 64'(sb.size()), 64'd2);
      rst_n = 1'b0;
      #1;
      chk("t6_rvalid_in_reset", 64'(rvalid_o), 64'd0);
      chk("t6_ready_in_reset", 64'(req_ready_o), 64'd0);
      sb.delete();
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      rready_i = 1'b1;
      step(acc);
      chk("t6_no_stale_resp", 64'(rvalid_o), 64'd0);
      n_acc = 0;
      req_valid_i = 1'b1;
      for (int i = 0; i < 200 && n_acc < 64; i++) begin
         req_addr_i = {8'hA5, 50'd0, 6'(n_acc), 6'd0};
         step(acc);
         if (acc) n_acc++;
      end
      req_valid_i = 1'b0;
      chk("t6_all_sets_looked_up", 64'(n_acc), 64'd64);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
